cursor_blink_overlay: RTL and testbench
=======================================

# cursor_blink_overlay

Downstream consumer of the white-cursor blink timer in the paint datapath. It drives that timer's `init` input, watches its `CB` flag, and keeps a blink phase bit that toggles once per timer expiry. It then overlays the cursor onto the outgoing pixel stream headed for the LED-matrix writer, so the cursor pixel flashes while the rest of the canvas passes through unchanged.

## Interface
Parameters:
- `X_W`, default 6: pixel/cursor column width (64 columns).
- `Y_W`, default 5: pixel/cursor row width (32 rows).
- `PIX_W`, default 24: pixel colour width (RGB888).
- `CURSOR_COLOR`, default 24'hFFFFFF: colour forced onto the cursor pixel when the phase is visible.

Ports:
- `clk`, input, 1: single system clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `blink_en`, input, 1: level; 1 = cursor blinks, 0 = blinking halted.
- `cursor_move`, input, 1: one-cycle pulse when the cursor position changes.
- `cursor_x`, input, `X_W`: cursor column.
- `cursor_y`, input, `Y_W`: cursor row.
- `CB`, input, 1: blink-timer expired flag. It is a level held high from expiry until the next `init`.
- `init_blink`, output, 1: one-cycle pulse that re-arms the blink timer (drives its `init`).
- `blink_phase`, output, 1: 1 = cursor visible.
- `pix_valid`, input, 1: input pixel qualifier.
- `pix_x`, input, `X_W`: column of the input pixel.
- `pix_y`, input, `Y_W`: row of the input pixel.
- `pix_data`, input, `PIX_W`: input pixel colour.
- `out_valid`, output, 1: output pixel qualifier.
- `out_data`, output, `PIX_W`: output pixel colour.

## Operation
FSM states: IDLE, ARM, WAIT_CB.
- **IDLE**
  - `blink_phase` is held at 1, so the cursor shows solid while halted.
  - `blink_en`=1 moves to ARM.
- **ARM**
  - `init_blink`=1 for exactly this cycle.
  - Always moves to WAIT_CB.
- **WAIT_CB**
  - The cycle of WAIT_CB entered directly from ARM ignores `CB`. The timer clears `CB` one cycle after `init`.
  - After that cycle, `CB`=1 toggles `blink_phase` and moves to ARM.
- **From any state:**
  - `blink_en`=0 forces IDLE next cycle, with `blink_phase`=1.
  - `cursor_move`=1 with `blink_en`=1 sets `blink_phase`=1 and moves to ARM. This restarts the period so a moving cursor is always visible.
  - `cursor_move` has priority over `CB` in the same cycle: no toggle, phase is 1.

Pixel overlay:
- `hit` = (`pix_x`==`cursor_x`) && (`pix_y`==`cursor_y`).
- `out_data` = (`hit` && `blink_phase`) ? overlay colour : `pix_data`.
- The `blink_phase` used is the registered value in the cycle the pixel is accepted.
- `out_valid` follows `pix_valid`.
- When `pix_valid`=0, `out_data` holds its previous value.
- Coordinates are compared at full width; there is no wrap or clipping.

## Timing
- Reset (`rst`=1 at a clock edge): state IDLE, `blink_phase`=0, `init_blink`=0, `out_valid`=0, `out_data`=0.
  - Reset mid-period abandons the period. After release, the block starts again from IDLE.
- The first `init_blink` fires 2 cycles after `blink_en` is sampled high in IDLE (IDLE→ARM, then pulse).
- `CB` sampled high in WAIT_CB:
  - `blink_phase` toggles on the next edge.
  - `init_blink` pulses in the following cycle.
  - Phase period = timer period + 2 cycles.
- `cursor_move`: `blink_phase`=1 and state ARM on the next edge; `init_blink` pulses one cycle later.
- Pixel path: fixed 1-cycle latency. Inputs at edge N appear on `out_valid`/`out_data` after edge N+1. Full throughput, one pixel per cycle, no backpressure.

## Configuration
- `CURSOR_INVERT_EN` defined:
  - The overlay colour is `~pix_data`, so the cursor stays visible over white canvas.
  - `CURSOR_COLOR` is unused.
- `CURSOR_INVERT_EN` undefined: the overlay colour is `CURSOR_COLOR`.

## Test plan
- Reset, then `blink_en`=1:
  - `init_blink` pulses exactly once, 2 cycles after `blink_en` is sampled.
  - `blink_phase` stays 1 until `CB` rises.
- Timer model with a period of 10 cycles and `CB` held until `init`:
  - `blink_phase` toggles every 12 cycles.
  - There is one `init_blink` per toggle.
  - There is no toggle in the cycle right after ARM.
- `cursor_move` and `CB` asserted in the same cycle with `blink_phase`=0:
  - The next cycle has `blink_phase`=1 and state ARM.
  - No extra toggle occurs.
- Cursor at (3,7), stream pixel (3,7) with `pix_data`=24'h123456 and `pix_valid`=1:
  - Phase 1: `out_data`=24'hFFFFFF one cycle later, or 24'hEDCBA9 with `CURSOR_INVERT_EN`.
  - Phase 0: `out_data`=24'h123456.
- Stream pixel (4,7) with `pix_data`=24'h00FF00: `out_data`=24'h00FF00 in either phase; `out_valid` is `pix_valid` delayed by one cycle.
- `blink_en` dropped mid-period, then `rst` asserted mid-WAIT_CB:
  - Dropping `blink_en` gives IDLE with `blink_phase`=1 on the next edge.
  - Asserting `rst` sets all outputs to 0 on the next edge, and no `init_blink` pulses until `blink_en` is re-sampled.

Source files
------------

// File: rtl/cursor_blink_overlay.sv
// Cursor blink controller and pixel overlay: re-arms the blink timer, toggles the phase on
// each expiry, and paints the cursor pixel when visible. Define CURSOR_INVERT_EN to invert instead.
module cursor_blink_overlay #(
  parameter int                X_W          = 6,
  parameter int                Y_W          = 5,
  parameter int                PIX_W        = 24,
  parameter logic [PIX_W-1:0]  CURSOR_COLOR = 24'hFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_en,
  input  logic             cursor_move,
  input  logic [X_W-1:0]   cursor_x,
  input  logic [Y_W-1:0]   cursor_y,
  input  logic             CB,
  output logic             init_blink,
  output logic             blink_phase,
  input  logic             pix_valid,
  input  logic [X_W-1:0]   pix_x,
  input  logic [Y_W-1:0]   pix_y,
  input  logic [PIX_W-1:0] pix_data,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_CB} state_t;

  state_t state;
  // Set on the first WAIT_CB cycle, when CB may still be the stale level from before init.
  logic   cb_skip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      blink_phase <= 1'b0;
      init_blink  <= 1'b0;
      cb_skip     <= 1'b0;
    end else begin
      init_blink <= (state == ARM);
      if (!blink_en) begin
        state       <= IDLE;
        blink_phase <= 1'b1;
      end else if (cursor_move) begin
        state       <= ARM;
        blink_phase <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            blink_phase <= 1'b1;
            state       <= ARM;
          end
          ARM: begin
            state   <= WAIT_CB;
            cb_skip <= 1'b1;
          end
          WAIT_CB: begin
            if (cb_skip) begin
              cb_skip <= 1'b0;
            end else if (CB) begin
              blink_phase <= ~blink_phase;
              state       <= ARM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic             hit;
  logic [PIX_W-1:0] overlay;

  assign hit = (pix_x == cursor_x) && (pix_y == cursor_y);
`ifdef CURSOR_INVERT_EN
  assign overlay = ~pix_data;
`else
  assign overlay = CURSOR_COLOR;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= pix_valid;
      if (pix_valid)
        out_data <= (hit && blink_phase) ? overlay : pix_data;
    end
  end

endmodule

// File: tb/tb_cursor_blink_overlay.sv
// Randomized bench for cursor_blink_overlay against a behavioural model plus a 10-cycle blink timer.
module tb_cursor_blink_overlay;

  logic        clk = 1'b0;
  logic        rst, blink_en, cursor_move, cb, pix_valid;
  logic [5:0]  cursor_x, pix_x;
  logic [4:0]  cursor_y, pix_y;
  logic [23:0] pix_data;
  logic        init_blink, blink_phase, out_valid;
  logic [23:0] out_data;

  always #5 clk = ~clk;

  cursor_blink_overlay dut (
    .clk(clk), .rst(rst), .blink_en(blink_en), .cursor_move(cursor_move),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .CB(cb),
    .init_blink(init_blink), .blink_phase(blink_phase),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  int n_vec = 0, n_err = 0;

  // Model: running/pending-arm/cycles-waited rather than a state encoding.
  bit          m_run, m_pend, m_phase, m_init, m_ov;
  int          m_age;
  logic [23:0] m_od;
  int          t_cnt = 0;
  int          tick_no = 0;

  function automatic logic [23:0] ovl(input logic [23:0] d);
`ifdef CURSOR_INVERT_EN
    return ~d;
`else
    return 24'hFFFFFF;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit pre_phase, pre_init;
    pre_phase = m_phase;
    pre_init  = m_init;
    @(posedge clk);
    #1;
    tick_no++;
    if (rst) begin
      m_run = 0; m_pend = 0; m_age = 0; m_phase = 0; m_init = 0; m_ov = 0; m_od = '0;
    end else begin
      m_init = m_pend;
      if (!blink_en) begin
        m_run = 0; m_pend = 0; m_phase = 1;
      end else if (cursor_move || !m_run) begin
        m_run = 1; m_pend = 1; m_phase = 1;
      end else if (m_pend) begin
        m_pend = 0; m_age = 0;
      end else if (m_age >= 1 && cb) begin
        m_phase = !m_phase; m_pend = 1;
      end else begin
        m_age++;
      end
      m_ov = pix_valid;
      if (pix_valid)
        m_od = (pix_x == cursor_x && pix_y == cursor_y && pre_phase) ? ovl(pix_data) : pix_data;
    end
    // Blink timer: CB rises 10 cycles after the init cycle, held until the next init.
    if (pre_init) begin
      t_cnt = 1; cb = 1'b0;
    end else if (t_cnt != 0) begin
      if (t_cnt == 9) begin cb = 1'b1; t_cnt = 0; end
      else t_cnt++;
    end
    chk("init_blink", {31'd0, init_blink}, {31'd0, m_init});
    chk("blink_phase", {31'd0, blink_phase}, {31'd0, m_phase});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", {8'd0, out_data}, {8'd0, m_od});
  endtask

  task automatic rand_pix();
    pix_valid = ($urandom_range(0, 3) != 0);
    pix_x     = 6'($urandom_range(2, 5));
    pix_y     = 5'($urandom_range(6, 8));
    case ($urandom_range(0, 2))
      0: pix_data = 24'h123456;
      1: pix_data = 24'h00FF00;
      default: pix_data = 24'($urandom);
    endcase
  endtask

  initial begin
    int last_tog;
    bit prev_ph;
    rst = 1; blink_en = 0; cursor_move = 0; cb = 0;
    cursor_x = 6'd3; cursor_y = 5'd7;
    pix_valid = 0; pix_x = 0; pix_y = 0; pix_data = 0;
    m_run = 0; m_pend = 0; m_age = 0; m_phase = 0; m_init = 0; m_ov = 0; m_od = '0;
    tick(); tick();
    chk("rst_phase", {31'd0, blink_phase}, 32'd0);
    chk("rst_odata", {8'd0, out_data}, 32'd0);

    // First init pulse two edges after blink_en is sampled, exactly once.
    rst = 0; blink_en = 1;
    tick(); chk("first_init_e1", {31'd0, init_blink}, 32'd0);
    chk("idle_phase", {31'd0, blink_phase}, 32'd1);
    tick(); chk("first_init_e2", {31'd0, init_blink}, 32'd1);
    tick(); chk("first_init_e3", {31'd0, init_blink}, 32'd0);

    // Free-running blink: toggle interval must be 12.
    last_tog = -1; prev_ph = m_phase;
    for (int i = 0; i < 80; i++) begin
      rand_pix();
      tick();
      if (m_phase != prev_ph) begin
        if (last_tog >= 0) chk("toggle_period", tick_no - last_tog, 32'd12);
        last_tog = tick_no;
      end
      prev_ph = m_phase;
    end

    // Directed hits in both phases.
    pix_valid = 1; pix_x = 3; pix_y = 7; pix_data = 24'h123456;
    prev_ph = m_phase;
    tick();
    chk("hit_pixel", {8'd0, out_data}, prev_ph ? {8'd0, ovl(24'h123456)} : 32'h123456);
    pix_x = 4; pix_data = 24'h00FF00;
    tick(); chk("miss_pixel", {8'd0, out_data}, 32'h00FF00);
    pix_valid = 0;

    // cursor_move with CB while phase is 0 and past the ignore cycle.
    for (int i = 0; i < 40 && !(m_phase == 0 && m_run && !m_pend && m_age >= 1); i++) tick();
    chk("reached_phase0", {31'd0, m_phase}, 32'd0);
    cursor_move = 1; cb = 1;
    tick(); chk("move_phase", {31'd0, blink_phase}, 32'd1);
    cursor_move = 0;
    tick(); chk("move_init", {31'd0, init_blink}, 32'd1);
    chk("move_notoggle", {31'd0, blink_phase}, 32'd1);

    // Drop blink_en, resume, then reset mid-wait.
    blink_en = 0;
    tick(); chk("drop_phase", {31'd0, blink_phase}, 32'd1);
    blink_en = 1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1; pix_valid = 1;
    tick(); chk("mid_rst_phase", {31'd0, blink_phase}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 0; blink_en = 0; pix_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("no_init_idle", {31'd0, init_blink}, 32'd0);
    end
    blink_en = 1;

    // Random soak.
    for (int i = 0; i < 2000; i++) begin
      rand_pix();
      cursor_move = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 80) == 0) blink_en = ~blink_en;
      rst = ($urandom_range(0, 300) == 0);
      if ($urandom_range(0, 200) == 0) begin
        cursor_x = 6'($urandom_range(2, 5)); cursor_y = 5'($urandom_range(6, 8));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
